// File: rtl/sigmoid_pla.sv
// Two-stage piecewise-linear (PLAN) logistic sigmoid approximation, shift-only.
// Stage 1 registers sign and saturated magnitude; stage 2 registers the segment result.
module sigmoid_pla #(
   parameter int WI = 8,
   parameter int WF = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [WI+WF-1:0]  x,
   output logic [WI+WF-1:0]  y
);

   localparam int W = WI + WF;

   localparam logic [W-1:0] ONE     = W'(1) << WF;
   localparam logic [W-1:0] LSB     = W'(1);
   localparam logic [W-1:0] MOSTNEG = {1'b1, {(W-1){1'b0}}};
   localparam logic [W-1:0] MAXPOS  = {1'b0, {(W-1){1'b1}}};

   // Segment thresholds 5.0, 2.375, 1.0 and offsets 0.84375, 0.625, 0.5
   localparam logic [W-1:0] THRHI   = W'(5) << WF;
   localparam logic [W-1:0] THRMID  = W'(19) << (WF - 3);
   localparam logic [W-1:0] THRLO   = ONE;
   localparam logic [W-1:0] OFFHI   = W'(27) << (WF - 5);
   localparam logic [W-1:0] OFFMID  = W'(5) << (WF - 3);
   localparam logic [W-1:0] OFFLO   = ONE >> 1;

   logic         sign1;
   logic [W-1:0] mag1;
   logic [W-1:0] magNext;
   logic [W-1:0] p;
   logic [W-1:0] yNext;

   // The most negative input has no positive twin, so its magnitude clamps
   always_comb begin
      magNext = x;
      if (x == MOSTNEG) begin
         magNext = MAXPOS;
      end else if (x[W-1]) begin
         magNext = ~x + LSB;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sign1 <= 1'b0;
         mag1  <= '0;
      end else begin
         sign1 <= x[W-1];
         mag1  <= magNext;
      end
   end

   // Boundaries fall into the upper segment; negative inputs mirror around 0.5
   always_comb begin
      p = (mag1 >> 2) + OFFLO;
      if (mag1 >= THRHI) begin
         p = ONE;
      end else if (mag1 >= THRMID) begin
         p = (mag1 >> 5) + OFFHI;
      end else if (mag1 >= THRLO) begin
         p = (mag1 >> 3) + OFFMID;
      end
      yNext = sign1 ? (ONE - p) : p;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         y <= '0;
      end else begin
         y <= yNext;
      end
   end

endmodule

// File: tb/tb_sigmoid_pla.sv
// Directed and exhaustive-sweep bench for sigmoid_pla (WI=8, WF=8).
// Outputs are sampled on the falling edge; inputs change on the falling edge too.
module tb_sigmoid_pla;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] x   = 16'h0000;
   logic [15:0] y;

   int compared   = 0;
   int mismatched = 0;

   logic [15:0] vecQ[$];
   logic [15:0] obsQ[$];

   logic [15:0] dirX[$] = '{
      16'h0000, 16'h0644, 16'h0100, 16'h0080, 16'hFF00,
      16'h00FF, 16'h0100, 16'h025F, 16'h0260, 16'h04FF, 16'h0500, 16'h0300,
      16'h7FFF, 16'h7FFE, 16'h8000, 16'h8001, 16'h4000, 16'h3FFF,
      16'h0001, 16'hFFFF, 16'h0C89, 16'h10C4, 16'h1234};
   logic [15:0] dirY[$] = '{
      16'h0080, 16'h0100, 16'h00C0, 16'h00A0, 16'h0040,
      16'h00BF, 16'h00C0, 16'h00EB, 16'h00EB, 16'h00FF, 16'h0100, 16'h00F0,
      16'h0100, 16'h0100, 16'h0000, 16'h0000, 16'h0100, 16'h0100,
      16'h0080, 16'h0080, 16'h0100, 16'h0100, 16'h0100};

   sigmoid_pla #(.WI(8), .WF(8)) dut (
      .clk (clk),
      .rst (rst),
      .x   (x),
      .y   (y)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [15:0] observed,
                              input logic [15:0] expected);
      compared++;
      if (observed !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
      end
   endtask

   // Feeds vecQ one sample per cycle and collects the matching outputs two edges later
   task automatic applyStimulus();
      obsQ.delete();
      for (int i = 0; i < vecQ.size() + 2; i++) begin
         @(negedge clk);
         if (i >= 2) obsQ.push_back(y);
         if (i < vecQ.size()) x = vecQ[i];
      end
   endtask

   function automatic logic [15:0] model(input logic [15:0] v);
      int sv, mag, p;
      sv  = int'($signed(v));
      mag = (sv < 0) ? -sv : sv;
      if (mag > 32767) mag = 32767;
      if (mag >= 1280)     p = 256;
      else if (mag >= 608) p = mag / 32 + 216;
      else if (mag >= 256) p = mag / 8 + 160;
      else                 p = mag / 4 + 128;
      return 16'((sv < 0) ? 256 - p : p);
   endfunction

   initial begin
      #1 rst = 1'b0;
      x = 16'h1234;
      checkOutput("reset_async", y, 16'h0000);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         checkOutput($sformatf("reset_hold%0d", i), y, 16'h0000);
      end

      @(negedge clk);
      x   = 16'h0000;
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checkOutput($sformatf("release%0d", i), y, 16'h0080);
      end

      vecQ = dirX;
      applyStimulus();
      for (int i = 0; i < dirX.size(); i++)
         checkOutput($sformatf("dir x=%h", dirX[i]), obsQ[i], dirY[i]);

      @(negedge clk);
      x = 16'h0644;
      repeat (2) @(negedge clk);
      checkOutput("pre_midreset", y, 16'h0100);
      @(posedge clk); #2;
      rst = 1'b0;
      #1 checkOutput("midreset_async", y, 16'h0000);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      checkOutput("midreset_discard", y, 16'h0080);
      @(negedge clk);
      checkOutput("midreset_resume", y, 16'h0100);

      vecQ.delete();
      for (int v = 1; v <= 32767; v++) begin
         vecQ.push_back(16'(v));
         vecQ.push_back(16'(-v));
      end
      applyStimulus();
      for (int k = 0; k < vecQ.size(); k += 2) begin
         checkOutput($sformatf("sweep x=%h", vecQ[k]), obsQ[k], model(vecQ[k]));
         checkOutput($sformatf("sweep x=%h", vecQ[k+1]), obsQ[k+1], model(vecQ[k+1]));
         checkOutput($sformatf("symmetry x=%h", vecQ[k]), 16'(obsQ[k] + obsQ[k+1]),
                     16'h0100);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
